mem_arb2: RTL
=============

MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- HI_PRIO, 0: master index that wins simultaneous requests under fixed priority, and the first tie after reset under round-robin.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. The block uses one clock; reset is asynchronous and active-high.
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- m0_req_valid, in, 1: master 0 request valid.
- m0_req_ready, out, 1: master 0 request accepted.
- m0_req, in, mem_req_t: master 0 request.
- m0_resp_valid, out, 1: master 0 response valid.
- m0_resp_ready, in, 1: master 0 response accepted.
- m0_resp, out, mem_resp_t: master 0 response.
- m1_*, same directions and widths as m0_*: master 1 port.
- s_req_valid, out, 1: downstream request valid (feeds mem2wb).
- s_req_ready, in, 1: downstream request accepted.
- s_req, out, mem_req_t: downstream request.
- s_resp_valid, in, 1: downstream response valid.
- s_resp_ready, out, 1: downstream response accepted.
- s_resp, in, mem_resp_t: downstream response.

Function
REQ-003 The block SHALL arbitrate two mem masters onto one downstream mem port, with at most one transaction outstanding.
REQ-004 FSM states SHALL be ARB, REQ and RESP, held in a 2-bit register; any unused encoding SHALL go to ARB on the next clock.
REQ-005 ARB: if any mi_req_valid=1, the FSM SHALL register owner (1 bit) and go to REQ on the next clock; otherwise it SHALL stay in ARB.
REQ-006 REQ: s_req_valid=1 and s_req=m[owner]_req; on s_req_valid & s_req_ready the FSM SHALL go to RESP.
REQ-007 RESP: the FSM SHALL route s_resp to m[owner]_resp, with m[owner]_resp_valid=s_resp_valid and s_resp_ready=m[owner]_resp_ready; on that handshake it SHALL go to ARB.
REQ-008 m[owner]_req_ready SHALL equal s_req_ready only while in REQ; every other req_ready SHALL be 0.
REQ-009 Non-owner resp_valid SHALL be 0. s_resp_ready SHALL be 0 outside RESP.
REQ-010 Response fields SHALL pass combinationally (0-cycle). Request fields SHALL be muxed combinationally from the owner.
REQ-011 Minimum latency: request seen in ARB at cycle N -> s_req_valid at N+1.
REQ-012 Back-to-back transactions SHALL pass through ARB for one cycle, so the cycle after each response handshake is idle.
REQ-013 The owner SHALL NOT change while in REQ or RESP, even if the other master raises valid.
REQ-014 A master dropping req_valid while in REQ is a protocol violation; behaviour is then don't-care, but there SHALL be no lockup once rst is asserted.
REQ-015 s_resp_valid outside RESP SHALL be ignored and SHALL NOT be forwarded.

Reset
REQ-016 While rst=1, asynchronously: state=ARB, owner=HI_PRIO, last_grant=~HI_PRIO.
REQ-017 All valid and ready outputs SHALL be 0 during reset.
REQ-018 Reset asserted mid-transaction SHALL drop it without any response being emitted.
REQ-019 The first grant SHALL be possible in the first ARB cycle after rst deasserts.

Configuration
REQ-020 The macro SHALL be MEM_ARB_RR_EN.
REQ-021 With MEM_ARB_RR_EN defined, a tie in ARB SHALL go to ~last_grant, and last_grant SHALL update on every grant.
REQ-022 Without MEM_ARB_RR_EN, a tie SHALL always go to HI_PRIO, and last_grant SHALL not exist.
REQ-023 A lone requester SHALL win in both builds.

Verification
REQ-024 Single read: m0 read addr 0x1000 at cycle 2, s_req_ready at cycle 4, s_resp data 0xDEADBEEF at cycle 6 -> s_req at cycles 3-4, m0_resp_valid at cycle 6 carrying 0xDEADBEEF, m1 sees nothing.
REQ-025 Tie, RR build: m0 and m1 valid continuously for 4 transactions -> grants in order 0,1,0,1. Fixed build with HI_PRIO=0 -> 0,0,0,0 (m1 starves).
REQ-026 Owner lock: m1 raises valid while m0 is in RESP -> m1_req_ready stays 0 until m0's response handshake, then m1 is granted on the following ARB cycle.
REQ-027 Response backpressure: m0_resp_ready=0 for 5 cycles during RESP -> s_resp_ready=0 throughout, state held, data delivered intact once ready=1.
REQ-028 Reset in REQ: rst=1 for 2 cycles while s_req_valid=1 -> all outputs 0, state ARB, no response emitted; a new m1 request afterwards completes normally.
REQ-029 Stray s_resp_valid=1 asserted in ARB -> no mi_resp_valid and s_resp_ready=0.

Source files
------------

// File: rtl/mem_arb2.sv
// mem_arb2: two-master arbiter onto one downstream mem port, one transaction outstanding.
// Parameter HI_PRIO: master that wins ties (fixed build) or the first tie after reset (round-robin build).
// Ports: clk, rst (async, active-high); m0_*/m1_* master request/response ports;
//        s_* downstream request/response port. Request and response fields are muxed combinationally.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed priority.
package mem_arb2_pkg;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;
endpackage

module mem_arb2
  import mem_arb2_pkg::*;
#(
  parameter int HI_PRIO = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      m0_req_valid,
  output logic      m0_req_ready,
  input  mem_req_t  m0_req,
  output logic      m0_resp_valid,
  input  logic      m0_resp_ready,
  output mem_resp_t m0_resp,
  input  logic      m1_req_valid,
  output logic      m1_req_ready,
  input  mem_req_t  m1_req,
  output logic      m1_resp_valid,
  input  logic      m1_resp_ready,
  output mem_resp_t m1_resp,
  output logic      s_req_valid,
  input  logic      s_req_ready,
  output mem_req_t  s_req,
  input  logic      s_resp_valid,
  output logic      s_resp_ready,
  input  mem_resp_t s_resp
);
  typedef enum logic [1:0] {ARB = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  localparam logic HP = (HI_PRIO != 0);
  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   grant, pick, prio, in_req, in_resp;
`ifdef MEM_ARB_RR_EN
  logic last_q;
  assign prio = ~last_q;
`else
  assign prio = HP;
`endif
  assign grant = (state_q == ARB) & (m0_req_valid | m1_req_valid);
  // A lone requester wins; on a tie the priority bit decides.
  assign pick  = (m0_req_valid & m1_req_valid) ? prio : m1_req_valid;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB: begin
        state_d = grant ? REQ : ARB;
        owner_d = grant ? pick : owner_q;
      end
      REQ:     state_d = s_req_ready ? RESP : REQ;
      RESP:    state_d = (s_resp_valid & s_resp_ready) ? ARB : RESP;
      default: state_d = ARB;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      owner_q <= HP;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= ~HP;
    else if (grant) last_q <= pick;
  end
`endif
  assign in_req        = (state_q == REQ);
  assign in_resp       = (state_q == RESP);
  assign s_req_valid   = in_req;
  assign s_req         = owner_q ? m1_req : m0_req;
  assign m0_req_ready  = in_req & ~owner_q & s_req_ready;
  assign m1_req_ready  = in_req & owner_q & s_req_ready;
  assign s_resp_ready  = in_resp & (owner_q ? m1_resp_ready : m0_resp_ready);
  // Responses outside RESP are stray and never forwarded.
  assign m0_resp_valid = in_resp & ~owner_q & s_resp_valid;
  assign m1_resp_valid = in_resp & owner_q & s_resp_valid;
  assign m0_resp       = s_resp;
  assign m1_resp       = s_resp;
endmodule
